// File: rtl/perf_counter_bank_if.sv
// Dump stream of perf_counter_bank: one counter per valid/ready beat, plus a completion flag.
interface perf_counter_bank_if #(
  parameter int CNT_W = 32,
  parameter int SEL_W = 3
);
  logic             dump_valid;
  logic             dump_ready;
  logic [SEL_W-1:0] dump_idx;
  logic [CNT_W-1:0] dump_data;
  logic             done;

  modport master (output dump_valid, dump_idx, dump_data, done, input dump_ready);
  modport slave  (input dump_valid, dump_idx, dump_data, done, output dump_ready);
endinterface

// File: rtl/perf_counter_bank.sv
// Event/cycle counter bank: counts strobes while running, freezes on halt and streams
// every counter out over the dump port; also offers a registered random-access read.
module perf_counter_bank #(
  parameter int NUM_EVT  = 5,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_EVT-1:0]           evt,
  input  logic                         halt,
  input  logic                         clr,
  input  logic [$clog2(NUM_EVT+1)-1:0] rd_sel,
  output logic [CNT_W-1:0]             rd_data,
  output logic [NUM_EVT:0]             ovf,
  perf_counter_bank_if.master          dumpIf
);
  localparam int SEL_W = $clog2(NUM_EVT+1);
  localparam int NCNT  = NUM_EVT + 1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_EVT);

  typedef enum logic [1:0] {RUN, DUMP, DONE} stateT;

  stateT            state, nextState;
  logic [SEL_W-1:0] dumpIdx, nextIdx;
  logic [CNT_W-1:0] cnt [NCNT];
  logic [CNT_W-1:0] dumpData;
  logic [NCNT-1:0]  incr;
  logic             counting, clearing;

  // The top counter is the cycle counter, so it always sees an increment.
  assign incr     = {1'b1, evt};
  assign counting = (state == RUN) && !clr;
  assign clearing = (state != DUMP) && clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      dumpIdx <= '0;
    end else begin
      state   <= nextState;
      dumpIdx <= nextIdx;
    end
  end

  always_comb begin
    nextState = state;
    nextIdx   = dumpIdx;
    case (state)
      RUN: begin
        if (halt && !clr) begin
          nextState = DUMP;
          nextIdx   = '0;
        end
      end
      DUMP: begin
        if (dumpIf.dump_ready) begin
          if (dumpIdx == LAST_IDX) nextState = DONE;
          else                     nextIdx   = dumpIdx + SEL_W'(1);
        end
      end
      DONE: begin
        if (clr) nextState = RUN;
      end
      default: nextState = RUN;
    endcase
  end

  // Counters and sticky overflow flags; clear wins over the same cycle's events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (clearing) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (counting) begin
      for (int i = 0; i < NCNT; i++) begin
        if (incr[i]) begin
          if (&cnt[i]) begin
            ovf[i] <= 1'b1;
            cnt[i] <= (SATURATE != 0) ? cnt[i] : '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= '0;
      for (int i = 0; i < NCNT; i++) begin
        if (rd_sel == SEL_W'(i)) rd_data <= cnt[i];
      end
    end
  end

  always_comb begin
    dumpData = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (dumpIdx == SEL_W'(i)) dumpData = cnt[i];
    end
  end

  assign dumpIf.dump_valid = (state == DUMP);
  assign dumpIf.done       = (state == DONE);
  assign dumpIf.dump_idx   = dumpIdx;
  assign dumpIf.dump_data  = dumpData;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a 32-bit wrapping bank plus 4-bit wrap and saturate banks
// sharing the same stimulus; expected dump beats are queued as stimulus is driven.
module tb_perf_counter_bank;
  logic        clk;
  logic        rst;
  logic [4:0]  evt;
  logic        halt;
  logic        clr;
  logic [2:0]  rdSel;
  logic        dumpReady;
  logic [31:0] rdDataMain;
  logic [3:0]  rdDataWrap, rdDataSat;
  logic [5:0]  ovfMain, ovfWrap, ovfSat;

  int vectorsApplied = 0;
  int miscompares    = 0;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
  } beatT;
  beatT expQ[$];

  perf_counter_bank_if #(.CNT_W(32), .SEL_W(3)) busMain ();
  perf_counter_bank_if #(.CNT_W(4),  .SEL_W(3)) busWrap ();
  perf_counter_bank_if #(.CNT_W(4),  .SEL_W(3)) busSat ();

  assign busMain.dump_ready = dumpReady;
  assign busWrap.dump_ready = dumpReady;
  assign busSat.dump_ready  = dumpReady;

  perf_counter_bank #(.NUM_EVT(5), .CNT_W(32), .SATURATE(0)) dutMain (
    .clk(clk), .rst(rst), .evt(evt), .halt(halt), .clr(clr), .rd_sel(rdSel),
    .rd_data(rdDataMain), .ovf(ovfMain), .dumpIf(busMain));

  perf_counter_bank #(.NUM_EVT(5), .CNT_W(4), .SATURATE(0)) dutWrap (
    .clk(clk), .rst(rst), .evt(evt), .halt(halt), .clr(clr), .rd_sel(rdSel),
    .rd_data(rdDataWrap), .ovf(ovfWrap), .dumpIf(busWrap));

  perf_counter_bank #(.NUM_EVT(5), .CNT_W(4), .SATURATE(1)) dutSat (
    .clk(clk), .rst(rst), .evt(evt), .halt(halt), .clr(clr), .rd_sel(rdSel),
    .rd_data(rdDataSat), .ovf(ovfSat), .dumpIf(busSat));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle's inputs, take the edge, and return 1 time unit after it.
  task automatic applyStimulus(input logic [4:0] e, input logic h, input logic c);
    evt  = e;
    halt = h;
    clr  = c;
    @(posedge clk);
    #1;
  endtask

  // Reset is released between edges so the very next edge is the first counted cycle.
  task automatic applyReset();
    rst = 1'b1; evt = '0; halt = 1'b0; clr = 1'b0; dumpReady = 1'b0; rdSel = '0;
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic runBasicSetup();
    for (int i = 0; i < 4; i++) applyStimulus(5'b00001, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(5'b00100, 1'b0, 1'b0);
    applyStimulus(5'b00001, 1'b1, 1'b0);
    evt = '0; halt = 1'b0;
    expQ.push_back('{3'd0, 32'd5});
    expQ.push_back('{3'd1, 32'd0});
    expQ.push_back('{3'd2, 32'd2});
    expQ.push_back('{3'd3, 32'd0});
    expQ.push_back('{3'd4, 32'd0});
    expQ.push_back('{3'd5, 32'd7});
  endtask

  task automatic test_reset();
    rst = 1'b1; evt = '0; halt = 1'b0; clr = 1'b0; dumpReady = 1'b0; rdSel = '0;
    #2;
    vectorsApplied++;
    if (busMain.dump_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset dump_valid: got %b expected 0", busMain.dump_valid); end
    vectorsApplied++;
    if (busMain.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset done: got %b expected 0", busMain.done); end
    vectorsApplied++;
    if (busMain.dump_idx !== 3'd0) begin miscompares++; $display("[TB] FAIL reset dump_idx: got %0d expected 0", busMain.dump_idx); end
    vectorsApplied++;
    if (busMain.dump_data !== 32'd0) begin miscompares++; $display("[TB] FAIL reset dump_data: got %0d expected 0", busMain.dump_data); end
    vectorsApplied++;
    if (rdDataMain !== 32'd0) begin miscompares++; $display("[TB] FAIL reset rd_data: got %0d expected 0", rdDataMain); end
    vectorsApplied++;
    if (ovfMain !== 6'd0) begin miscompares++; $display("[TB] FAIL reset ovf: got %b expected 000000", ovfMain); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_dump();
    int   beats  = 0;
    int   cycles = 0;
    beatT b;
    applyReset();
    dumpReady = 1'b1;
    runBasicSetup();
    vectorsApplied++;
    if (busMain.dump_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic valid after halt: got %b expected 1", busMain.dump_valid); end
    while (busMain.dump_valid === 1'b1 && cycles < 20) begin
      if (expQ.size() == 0) begin
        vectorsApplied++; miscompares++;
        $display("[TB] FAIL basic extra beat: got idx %0d expected no beat", busMain.dump_idx);
        break;
      end
      b = expQ.pop_front();
      vectorsApplied++;
      if (busMain.dump_idx !== b.idx) begin miscompares++; $display("[TB] FAIL basic idx: got %0d expected %0d", busMain.dump_idx, b.idx); end
      vectorsApplied++;
      if (busMain.dump_data !== b.data) begin miscompares++; $display("[TB] FAIL basic data idx%0d: got %0d expected %0d", b.idx, busMain.dump_data, b.data); end
      beats++;
      applyStimulus(5'b00000, 1'b0, 1'b0);
      cycles++;
    end
    vectorsApplied++;
    if (beats != 6 || cycles != 6) begin miscompares++; $display("[TB] FAIL basic beat count: got %0d beats in %0d cycles expected 6 in 6", beats, cycles); end
    vectorsApplied++;
    if (busMain.done !== 1'b1) begin miscompares++; $display("[TB] FAIL basic done: got %b expected 1", busMain.done); end
    applyStimulus(5'b00000, 1'b1, 1'b0);
    vectorsApplied++;
    if (busMain.done !== 1'b1 || busMain.dump_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL done halt ignored: got done %b valid %b expected 1 0", busMain.done, busMain.dump_valid); end
    applyStimulus(5'b00001, 1'b1, 1'b1);
    vectorsApplied++;
    if (busMain.done !== 1'b0 || busMain.dump_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL done clr to run: got done %b valid %b expected 0 0", busMain.done, busMain.dump_valid); end
    applyStimulus(5'b00001, 1'b1, 1'b0);
    vectorsApplied++;
    if (busMain.dump_valid !== 1'b1 || busMain.dump_idx !== 3'd0) begin miscompares++; $display("[TB] FAIL redump entry: got valid %b idx %0d expected 1 0", busMain.dump_valid, busMain.dump_idx); end
    vectorsApplied++;
    if (busMain.dump_data !== 32'd1) begin miscompares++; $display("[TB] FAIL redump data: got %0d expected 1", busMain.dump_data); end
  endtask

  // Stalls carry clr and a full event burst, both of which a dump must ignore.
  task automatic test_backpressure();
    int   beats = 0;
    int   guard = 0;
    logic readyBit;
    beatT b;
    applyReset();
    runBasicSetup();
    for (int i = 0; i < 3; i++) begin
      vectorsApplied++;
      if (busMain.dump_valid !== 1'b1 || busMain.dump_idx !== 3'd0 || busMain.dump_data !== 32'd5) begin
        miscompares++;
        $display("[TB] FAIL stall hold %0d: got valid %b idx %0d data %0d expected 1 0 5", i, busMain.dump_valid, busMain.dump_idx, busMain.dump_data);
      end
      applyStimulus(5'b11111, 1'b0, 1'b1);
    end
    readyBit = 1'b1;
    while (busMain.done !== 1'b1 && guard < 40) begin
      dumpReady = readyBit;
      if (busMain.dump_valid === 1'b1 && readyBit) begin
        if (expQ.size() == 0) begin
          vectorsApplied++; miscompares++;
          $display("[TB] FAIL bp extra beat: got idx %0d expected no beat", busMain.dump_idx);
        end else begin
          b = expQ.pop_front();
          vectorsApplied++;
          if (busMain.dump_idx !== b.idx || busMain.dump_data !== b.data) begin
            miscompares++;
            $display("[TB] FAIL bp beat: got idx %0d data %0d expected idx %0d data %0d", busMain.dump_idx, busMain.dump_data, b.idx, b.data);
          end
        end
        beats++;
      end
      applyStimulus(5'b00000, 1'b0, 1'b0);
      readyBit = ~readyBit;
      guard++;
    end
    vectorsApplied++;
    if (busMain.done !== 1'b1) begin miscompares++; $display("[TB] FAIL bp timeout: got done %b expected 1 within 40 cycles", busMain.done); end
    vectorsApplied++;
    if (beats != 6 || expQ.size() != 0) begin miscompares++; $display("[TB] FAIL bp beat count: got %0d beats, %0d left expected 6, 0", beats, expQ.size()); end
  endtask

  task automatic test_clear();
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(5'b00001, 1'b0, 1'b0);
    vectorsApplied++;
    if (rdDataMain !== 32'd2) begin miscompares++; $display("[TB] FAIL clear precount: got %0d expected 2", rdDataMain); end
    applyStimulus(5'b00001, 1'b0, 1'b1);
    vectorsApplied++;
    if (rdDataMain !== 32'd3) begin miscompares++; $display("[TB] FAIL clear edge read: got %0d expected 3", rdDataMain); end
    applyStimulus(5'b00000, 1'b0, 1'b0);
    vectorsApplied++;
    if (rdDataMain !== 32'd0) begin miscompares++; $display("[TB] FAIL clear result: got %0d expected 0", rdDataMain); end
    applyStimulus(5'b00000, 1'b1, 1'b1);
    vectorsApplied++;
    if (busMain.dump_valid !== 1'b0 || busMain.done !== 1'b0) begin miscompares++; $display("[TB] FAIL clr over halt: got valid %b done %b expected 0 0", busMain.dump_valid, busMain.done); end
    rdSel = 3'd5;
    applyStimulus(5'b00000, 1'b0, 1'b0);
    vectorsApplied++;
    if (rdDataMain !== 32'd0) begin miscompares++; $display("[TB] FAIL clr cycle counter: got %0d expected 0", rdDataMain); end
  endtask

  task automatic test_overflow();
    applyReset();
    rdSel = 3'd1;
    for (int i = 0; i < 15; i++) applyStimulus(5'b00010, 1'b0, 1'b0);
    vectorsApplied++;
    if (ovfWrap !== 6'd0 || ovfSat !== 6'd0) begin miscompares++; $display("[TB] FAIL ovf early: got wrap %b sat %b expected 000000", ovfWrap, ovfSat); end
    vectorsApplied++;
    if (rdDataWrap !== 4'd14) begin miscompares++; $display("[TB] FAIL ovf count15 read: got %0d expected 14", rdDataWrap); end
    applyStimulus(5'b00010, 1'b0, 1'b0);
    vectorsApplied++;
    if (ovfWrap !== 6'b100010) begin miscompares++; $display("[TB] FAIL ovf wrap flags: got %b expected 100010", ovfWrap); end
    vectorsApplied++;
    if (ovfSat !== 6'b100010) begin miscompares++; $display("[TB] FAIL ovf sat flags: got %b expected 100010", ovfSat); end
    applyStimulus(5'b00010, 1'b0, 1'b0);
    applyStimulus(5'b00000, 1'b0, 1'b0);
    vectorsApplied++;
    if (rdDataWrap !== 4'd1) begin miscompares++; $display("[TB] FAIL ovf wrap count: got %0d expected 1", rdDataWrap); end
    vectorsApplied++;
    if (rdDataSat !== 4'd15) begin miscompares++; $display("[TB] FAIL ovf sat count: got %0d expected 15", rdDataSat); end
    vectorsApplied++;
    if (rdDataMain !== 32'd17 || ovfMain !== 6'd0) begin miscompares++; $display("[TB] FAIL ovf wide bank: got %0d ovf %b expected 17 000000", rdDataMain, ovfMain); end
  endtask

  // Continues from the overflow run so the small banks carry set ovf bits into the reset.
  task automatic test_async_reset();
    int guard = 0;
    dumpReady = 1'b1;
    applyStimulus(5'b00000, 1'b1, 1'b0);
    halt = 1'b0;
    while (busMain.dump_idx !== 3'd2 && guard < 10) begin
      applyStimulus(5'b00000, 1'b0, 1'b0);
      guard++;
    end
    vectorsApplied++;
    if (busMain.dump_idx !== 3'd2 || busMain.dump_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL arst reach idx2: got idx %0d valid %b expected 2 1", busMain.dump_idx, busMain.dump_valid); end
    #2;
    rst = 1'b1;
    #1;
    vectorsApplied++;
    if (busMain.dump_valid !== 1'b0 || busMain.done !== 1'b0) begin miscompares++; $display("[TB] FAIL arst outputs: got valid %b done %b expected 0 0", busMain.dump_valid, busMain.done); end
    vectorsApplied++;
    if (busMain.dump_idx !== 3'd0 || busMain.dump_data !== 32'd0) begin miscompares++; $display("[TB] FAIL arst dump port: got idx %0d data %0d expected 0 0", busMain.dump_idx, busMain.dump_data); end
    vectorsApplied++;
    if (ovfWrap !== 6'd0 || ovfSat !== 6'd0 || busWrap.dump_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL arst small banks: got ovf %b %b valid %b expected 0", ovfWrap, ovfSat, busWrap.dump_valid); end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    rdSel = 3'd0;
    applyStimulus(5'b00000, 1'b0, 1'b0);
    vectorsApplied++;
    if (rdDataMain !== 32'd0 || busMain.dump_valid !== 1'b0 || busMain.done !== 1'b0) begin miscompares++; $display("[TB] FAIL arst run state: got rd %0d valid %b done %b expected 0 0 0", rdDataMain, busMain.dump_valid, busMain.done); end
    rdSel = 3'd5;
    applyStimulus(5'b00000, 1'b0, 1'b0);
    vectorsApplied++;
    if (rdDataMain !== 32'd1 || rdDataWrap !== 4'd1) begin miscompares++; $display("[TB] FAIL arst cycle restart: got %0d %0d expected 1 1", rdDataMain, rdDataWrap); end
  endtask

  task automatic test_read_port();
    applyReset();
    for (int i = 0; i < 9; i++) applyStimulus(5'b00000, 1'b0, 1'b0);
    rdSel = 3'd5;
    applyStimulus(5'b00000, 1'b0, 1'b0);
    vectorsApplied++;
    if (rdDataMain !== 32'd9) begin miscompares++; $display("[TB] FAIL read cycles: got %0d expected 9", rdDataMain); end
    rdSel = 3'd7;
    applyStimulus(5'b00000, 1'b0, 1'b0);
    vectorsApplied++;
    if (rdDataMain !== 32'd0) begin miscompares++; $display("[TB] FAIL read sel7: got %0d expected 0", rdDataMain); end
    rdSel = 3'd6;
    applyStimulus(5'b00000, 1'b0, 1'b0);
    vectorsApplied++;
    if (rdDataMain !== 32'd0) begin miscompares++; $display("[TB] FAIL read sel6: got %0d expected 0", rdDataMain); end
    rdSel = 3'd5;
    applyStimulus(5'b00000, 1'b0, 1'b0);
    vectorsApplied++;
    if (rdDataMain !== 32'd12) begin miscompares++; $display("[TB] FAIL read cycles later: got %0d expected 12", rdDataMain); end
  endtask

  initial begin
    $display("[TB] perf_counter_bank bench starting");
    test_reset();
    test_basic_dump();
    test_backpressure();
    test_clear();
    test_overflow();
    test_async_reset();
    test_read_port();
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end
endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Synthesizable, parametrised event-counter bank that moves the processor's instruction, cache-request and cache-hit statistics out of the simulation bench and into RTL. It sits beside the pipeline inside `proc_hier` and counts one-cycle event strobes plus total cycles. It freezes on halt and streams every count out through a valid/ready dump port. A registered random-access read port is also provided.

## Interface
- `NUM_EVT`, 5, number of event channels. Recommended mapping: 0 = retired inst, 1 = ICacheReq, 2 = ICacheHit, 3 = DCacheReq, 4 = DCacheHit.
- `CNT_W`, 32, width of every counter.
- `SATURATE`, 0, overflow mode: 0 = wrap, 1 = saturate at all-ones.
- `SEL_W`, `$clog2(NUM_EVT+1)` (derived, localparam), index width.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `evt`  in  NUM_EVT  per-channel event strobe, sampled each rising edge.
- `halt`  in  1  level; processor halted.
- `clr`  in  1  synchronous clear of counters and overflow flags.
- `rd_sel`  in  SEL_W  read index; index NUM_EVT selects the cycle counter.
- `rd_data`  out  CNT_W  registered read data.
- `dump_valid`  out  1  dump beat valid.
- `dump_ready`  in  1  consumer accepts the beat.
- `dump_idx`  out  SEL_W  channel index of the current beat.
- `dump_data`  out  CNT_W  count for `dump_idx`.
- `done`  out  1  dump complete.
- `ovf`  out  NUM_EVT+1  sticky overflow per counter; bit NUM_EVT is the cycle counter.

## Operation
- Counters: `cnt[0..NUM_EVT-1]` for events and `cnt[NUM_EVT]` for cycles.
- FSM states are RUN, DUMP and DONE. Reset enters RUN.
- **RUN**
  - The cycle counter increments every edge.
  - `cnt[i]` increments when `evt[i]`=1.
  - The halt cycle is counted, for both its events and the cycle itself.
- **Leaving RUN**
  - `halt`=1 and `clr`=0 at an edge: the counters take that edge's increment, the FSM moves to DUMP, and `dump_idx` is set to 0.
  - `clr`=1: all counters and `ovf` go to 0, and the same cycle's events are discarded.
  - `clr`=1 has priority over `halt`: the FSM stays in RUN.
- **DUMP**
  - Counters are frozen; `evt` is ignored and `clr` is ignored.
  - `dump_valid`=1 and `dump_data`=`cnt[dump_idx]`.
  - A beat completes on `dump_valid`&&`dump_ready`.
  - If `dump_idx`==NUM_EVT when the beat completes, the FSM goes to DONE; otherwise `dump_idx` increments.
  - `dump_idx` and `dump_data` hold stable while `dump_ready`=0.
- **DONE**
  - `done`=1, `dump_valid`=0, counters frozen, `halt` ignored.
  - `clr`=1 zeroes the counters and `ovf` and returns to RUN.
  - If `halt` is still high after that return, DUMP is re-entered on the next edge.
- **Overflow**
  - An increment from all-ones sets `ovf[i]`, which is sticky until `clr` or `rst`.
  - SATURATE=0: the counter wraps to 0.
  - SATURATE=1: the counter holds at all-ones.
- **Read port**
  - `rd_data` <= `cnt[rd_sel]`, using the pre-increment value, in all states.
  - `rd_sel` > NUM_EVT gives 0.

## Timing
- Reset values: all counters 0, `ovf` 0, state RUN.
- Reset output values: `dump_valid` 0, `dump_idx` 0, `dump_data` 0, `done` 0, `rd_data` 0.
- Async `rst` clears everything immediately, mid-DUMP included. Outputs reach reset values without waiting for a clock edge.
- Read latency is 1 cycle. `rd_data` after edge N equals `cnt[rd_sel]` as it was before edge N.
- `dump_valid` rises the cycle after the halting edge.
- The minimum dump is NUM_EVT+1 cycles (with `dump_ready` held high).
- `done` rises the cycle after the final handshake.
- `dump_valid`, `dump_idx`, `dump_data` and `done` are decoded from registered state only. There is no combinational path from any input to these outputs.

## Test plan
- **Basic count and dump**
  - Stimulus: release `rst`; `evt`=5'b00001 for 4 cycles, then 5'b00100 for 2 cycles, then `halt`=1 with `evt`=5'b00001 for 1 cycle; `dump_ready`=1.
  - Required: beats idx0..5 = 5, 0, 2, 0, 0, 7, then `done`=1.
- **Backpressure**
  - Stimulus: same setup, `dump_ready`=0 for 3 cycles, then toggled every cycle.
  - Required: idx0 and its data hold through the stall; exactly 6 beats, in order, with no duplicates or skips.
- **Overflow**
  - Stimulus: CNT_W=4, SATURATE=0, `evt[1]` high for 17 cycles.
  - Required: `cnt[1]`=1 and `ovf[1]`=1.
  - Stimulus: rerun with SATURATE=1.
  - Required: `cnt[1]`=15 and `ovf[1]`=1.
  - Required in both runs: the cycle counter does not set `ovf[5]` before 16 cycles.
- **Clear**
  - Stimulus: count 3 on ch0, then `clr` with `evt[0]`=1.
  - Required: `rd_data`(sel 0) reads 0 two cycles later.
  - Stimulus: `clr`+`halt` in the same cycle.
  - Required: state stays RUN.
  - Stimulus: `clr` during DUMP.
  - Required: ignored; the dump data is unchanged.
- **Async reset mid-dump**
  - Stimulus: assert `rst` between edges during beat idx2.
  - Required: `dump_valid`, `done` and `ovf` go to 0 immediately; after release, RUN with all counts 0.
- **Read port**
  - Stimulus: after 9 run cycles, `rd_sel`=5.
  - Required: `rd_data`=9 one cycle later.
  - Stimulus: `rd_sel`=7.
  - Required: `rd_data`=0.
